// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks destination fields of EX/MEM/WB, inserts load-use stalls, squashes
// on taken branches (when no delay slot), and selects operand forwarding.
module pipeline_hazard_ctrl #(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned DELAY_SLOT  = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [4:0]       id_ra,
   input  logic [4:0]       id_rb,
   input  logic [1:0]       id_sr,
   input  logic [4:0]       id_rd,
   input  logic             id_rf_le,
   input  logic             id_load,
   input  logic             ex_branch_taken,
   output logic             pc_le,
   output logic             if_id_le,
   output logic             id_nop,
   output logic             if_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             busy
);

   localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);
   localparam bit         Squash   = (DELAY_SLOT == 0);

   typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

   state_e           state_q;
   logic [3:0]       boot_cnt_q;
   logic             busy_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       ex_valid_q, ex_rf_le_q, ex_load_q;
   logic [4:0] ex_rd_q;
   logic       mem_valid_q, mem_rf_le_q;
   logic [4:0] mem_rd_q;
   logic       wb_valid_q, wb_rf_le_q;
   logic [4:0] wb_rd_q;

   logic ex_wr, ex_fwd_ok, mem_ok, wb_ok;
   logic load_use, br_flush, stall_req;

   // Priority select of the youngest stage producing src; r0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                          input logic ex_ok, input logic [4:0] ex_rd,
                                          input logic m_ok, input logic [4:0] m_rd,
                                          input logic w_ok, input logic [4:0] w_rd);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && (src != 5'd0)) begin
         if (ex_ok && (ex_rd == src)) begin
            sel = 2'b01;
         end else if (m_ok && (m_rd == src)) begin
            sel = 2'b10;
         end else if (w_ok && (w_rd == src)) begin
            sel = 2'b11;
         end
      end
      return sel;
   endfunction

   assign ex_wr     = ex_valid_q & ex_rf_le_q & (ex_rd_q != 5'd0);
   // A load in EX has no data yet; that case is resolved by stalling instead.
   assign ex_fwd_ok = ex_wr & ~ex_load_q;
   assign mem_ok    = mem_valid_q & mem_rf_le_q;
   assign wb_ok     = wb_valid_q & wb_rf_le_q;

   assign load_use  = id_valid & ex_wr & ex_load_q &
                      ((id_sr[0] & (id_rb == ex_rd_q)) | (id_sr[1] & (id_ra == ex_rd_q)));
   // A squashing branch kills the ID instruction, so it overrides any stall.
   assign br_flush  = Squash & ex_branch_taken & (state_q != StBoot);
   assign stall_req = (state_q == StRun) & load_use & ~br_flush;

   // Pipeline control outputs, combinational on ID inputs and EX tracking.
   always_comb begin
      pc_le    = 1'b1;
      if_id_le = 1'b1;
      id_nop   = 1'b0;
      if_flush = 1'b0;
      case (state_q)
         StRun: begin
            if (br_flush) begin
               id_nop   = 1'b1;
               if_flush = 1'b1;
            end else if (load_use) begin
               pc_le    = 1'b0;
               if_id_le = 1'b0;
               id_nop   = 1'b1;
            end
         end
         StStall: begin
            if (br_flush) begin
               id_nop   = 1'b1;
               if_flush = 1'b1;
            end
         end
         default: begin
            pc_le    = 1'b0;
            if_id_le = 1'b0;
            id_nop   = 1'b1;
            if_flush = 1'b1;
         end
      endcase
   end

   // Operand forwarding selects.
   always_comb begin
      fwd_a = fwd_sel(id_sr[1], id_ra, ex_fwd_ok, ex_rd_q, mem_ok, mem_rd_q, wb_ok, wb_rd_q);
      fwd_b = fwd_sel(id_sr[0], id_rb, ex_fwd_ok, ex_rd_q, mem_ok, mem_rd_q, wb_ok, wb_rd_q);
   end

   // Saturating load-use stall counter next value.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_req && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Sequencer FSM: boot hold, run, single-cycle load-use stall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StBoot;
         boot_cnt_q <= 4'd0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            StBoot: begin
               if (boot_cnt_q == BootLast) begin
                  state_q <= StRun;
                  busy_q  <= 1'b0;
               end else begin
                  boot_cnt_q <= boot_cnt_q + 4'd1;
               end
            end
            StRun: begin
               if (stall_req) begin
                  state_q <= StStall;
               end
            end
            StStall: state_q <= StRun;
            default: begin
               state_q <= StBoot;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Destination tracking shifts EX -> MEM -> WB once the pipeline is live.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid_q  <= 1'b0;
         ex_rf_le_q  <= 1'b0;
         ex_load_q   <= 1'b0;
         ex_rd_q     <= 5'd0;
         mem_valid_q <= 1'b0;
         mem_rf_le_q <= 1'b0;
         mem_rd_q    <= 5'd0;
         wb_valid_q  <= 1'b0;
         wb_rf_le_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
      end else if (state_q != StBoot) begin
         ex_valid_q  <= id_valid & ~id_nop;
         ex_rf_le_q  <= id_rf_le & id_valid & ~id_nop;
         ex_load_q   <= id_load & id_valid & ~id_nop;
         ex_rd_q     <= id_rd;
         mem_valid_q <= ex_valid_q;
         mem_rf_le_q <= ex_rf_le_q;
         mem_rd_q    <= ex_rd_q;
         wb_valid_q  <= mem_valid_q;
         wb_rf_le_q  <= mem_rf_le_q;
         wb_rd_q     <= mem_rd_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (delay slot kept / squashed,
// 16-bit / 4-bit counter) driven by the same directed instruction stream and
// checked every cycle against an instruction-queue model, plus literal checks.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid, id_rf_le, id_load, ex_branch_taken;
   logic [4:0] id_ra, id_rb, id_rd;
   logic [1:0] id_sr;

   logic        pc_le0, if_id_le0, id_nop0, if_flush0, busy0;
   logic [1:0]  fwd_a0, fwd_b0;
   logic [15:0] cnt0;
   logic        pc_le1, if_id_le1, id_nop1, if_flush1, busy1;
   logic [1:0]  fwd_a1, fwd_b1;
   logic [3:0]  cnt1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.BOOT_CYCLES(4), .DELAY_SLOT(1), .CNT_W(16)) dut0 (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_sr(id_sr), .id_rd(id_rd), .id_rf_le(id_rf_le), .id_load(id_load),
      .ex_branch_taken(ex_branch_taken), .pc_le(pc_le0), .if_id_le(if_id_le0),
      .id_nop(id_nop0), .if_flush(if_flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
      .stall_cnt(cnt0), .busy(busy0)
   );

   pipeline_hazard_ctrl #(.BOOT_CYCLES(4), .DELAY_SLOT(0), .CNT_W(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_sr(id_sr), .id_rd(id_rd), .id_rf_le(id_rf_le), .id_load(id_load),
      .ex_branch_taken(ex_branch_taken), .pc_le(pc_le1), .if_id_le(if_id_le1),
      .id_nop(id_nop1), .if_flush(if_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
      .stall_cnt(cnt1), .busy(busy1)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- model: queue of in-flight instruction records ----------
   typedef struct {
      bit       v;
      bit       we;
      bit       ld;
      bit [4:0] rd;
   } rec_t;

   rec_t pipe [2][3];      // [instance][0=EX,1=MEM,2=WB]
   int   boot_left [2];
   bit   stalled [2];
   int   cnt [2];
   int   cmax [2] = '{65535, 15};
   int   ds [2]   = '{1, 0};

   function automatic bit [1:0] src_of(input int i, input bit [4:0] r, input bit used);
      if (!used || r == 0) return 2'd0;
      for (int s = 0; s < 3; s++) begin
         if (pipe[i][s].v && pipe[i][s].we && pipe[i][s].rd == r) begin
            if (s == 0 && pipe[i][s].ld) continue;
            return 2'(s + 1);
         end
      end
      return 2'd0;
   endfunction

   function automatic void model_out(input int i, output bit pc, output bit ifid,
                                     output bit nop, output bit fl, output bit bsy,
                                     output bit [1:0] fa, output bit [1:0] fb,
                                     output bit stall);
      bit   flush_br, lu;
      rec_t ex;
      ex    = pipe[i][0];
      fa    = src_of(i, id_ra, id_sr[1]);
      fb    = src_of(i, id_rb, id_sr[0]);
      stall = 0;
      if (boot_left[i] > 0) begin
         pc = 0; ifid = 0; nop = 1; fl = 1; bsy = 1;
      end else begin
         bsy      = 0;
         flush_br = (ds[i] == 0) && ex_branch_taken;
         lu = !stalled[i] && id_valid && ex.v && ex.ld && ex.we && ex.rd != 0 &&
              ((id_sr[0] && id_rb == ex.rd) || (id_sr[1] && id_ra == ex.rd));
         if (flush_br) begin
            pc = 1; ifid = 1; nop = 1; fl = 1;
         end else if (lu) begin
            pc = 0; ifid = 0; nop = 1; fl = 0; stall = 1;
         end else begin
            pc = 1; ifid = 1; nop = 0; fl = 0;
         end
      end
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit pc, ifid, nop, fl, bsy, st;
      bit [1:0] fa, fb;
      rec_t nrec;
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            boot_left[i] <= 4;
            stalled[i]   <= 0;
            cnt[i]       <= 0;
            for (int s = 0; s < 3; s++) pipe[i][s] <= '{0, 0, 0, 5'd0};
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            model_out(i, pc, ifid, nop, fl, bsy, fa, fb, st);
            if (boot_left[i] > 0) begin
               boot_left[i] <= boot_left[i] - 1;
            end else begin
               stalled[i] <= st;
               if (st && cnt[i] < cmax[i]) cnt[i] <= cnt[i] + 1;
               nrec.v  = id_valid && !nop;
               nrec.we = id_rf_le;
               nrec.ld = id_load;
               nrec.rd = id_rd;
               pipe[i][0] <= nrec;
               pipe[i][1] <= pipe[i][0];
               pipe[i][2] <= pipe[i][1];
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit pc, ifid, nop, fl, bsy, st;
         bit [1:0] fa, fb;
         logic a_pc, a_ifid, a_nop, a_fl, a_bsy;
         logic [1:0] a_fa, a_fb;
         int a_cnt;
         model_out(i, pc, ifid, nop, fl, bsy, fa, fb, st);
         if (i == 0) begin
            a_pc = pc_le0; a_ifid = if_id_le0; a_nop = id_nop0; a_fl = if_flush0;
            a_bsy = busy0; a_fa = fwd_a0; a_fb = fwd_b0; a_cnt = int'(cnt0);
         end else begin
            a_pc = pc_le1; a_ifid = if_id_le1; a_nop = id_nop1; a_fl = if_flush1;
            a_bsy = busy1; a_fa = fwd_a1; a_fb = fwd_b1; a_cnt = int'(cnt1);
         end
         chk($sformatf("cyc%0d.pc_le", i), int'(a_pc), int'(pc));
         chk($sformatf("cyc%0d.if_id_le", i), int'(a_ifid), int'(ifid));
         chk($sformatf("cyc%0d.id_nop", i), int'(a_nop), int'(nop));
         chk($sformatf("cyc%0d.if_flush", i), int'(a_fl), int'(fl));
         chk($sformatf("cyc%0d.busy", i), int'(a_bsy), int'(bsy));
         chk($sformatf("cyc%0d.stall_cnt", i), a_cnt, cnt[i]);
         if (!nop) begin
            chk($sformatf("cyc%0d.fwd_a", i), int'(a_fa), int'(fa));
            chk($sformatf("cyc%0d.fwd_b", i), int'(a_fb), int'(fb));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input bit v, input bit [4:0] ra, input bit [4:0] rb, input bit [1:0] sr,
                      input bit [4:0] rd, input bit we, input bit ld, input bit br);
      id_valid = v; id_ra = ra; id_rb = rb; id_sr = sr;
      id_rd = rd; id_rf_le = we; id_load = ld; ex_branch_taken = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic boot_check(input string tag);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s.boot%0d.busy", tag, k), int'(busy0), 1);
         chk($sformatf("%s.boot%0d.pc_le", tag, k), int'(pc_le0), 0);
         tick();
      end
      chk($sformatf("%s.run.busy", tag), int'(busy0), 0);
      chk($sformatf("%s.run.pc_le", tag), int'(pc_le0), 1);
      chk($sformatf("%s.run.fwd_a", tag), int'(fwd_a0), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      drv(0, 0, 0, 2'b00, 0, 0, 0, 0);
      #1 reset_n = 1'b0;
      #1;
      chk("rst.pc_le", int'(pc_le0), 0);
      chk("rst.if_id_le", int'(if_id_le0), 0);
      chk("rst.id_nop", int'(id_nop0), 1);
      chk("rst.if_flush", int'(if_flush0), 1);
      chk("rst.busy", int'(busy0), 1);
      chk("rst.stall_cnt", int'(cnt0), 0);
      #10 reset_n = 1'b1;
      boot_check("boot");

      // load-use: LDW r5 then ADD using r5/r6
      drv(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
      drv(1, 5, 6, 2'b11, 7, 1, 0, 0); #1;
      chk("lu.pc_le", int'(pc_le0), 0);
      chk("lu.if_id_le", int'(if_id_le0), 0);
      chk("lu.id_nop", int'(id_nop0), 1);
      tick();
      chk("lu.stall_cnt", int'(cnt0), 1);
      chk("lu.fwd_a_mem", int'(fwd_a0), 2);
      chk("lu.fwd_b", int'(fwd_b0), 0);
      chk("lu.stall_pc_le", int'(pc_le0), 1);
      tick();

      // ALU result forwarded from EX, MEM, WB
      drv(1, 0, 0, 2'b00, 3, 1, 0, 0); tick();
      drv(1, 1, 3, 2'b01, 8, 1, 0, 0); #1;
      chk("fw.ex", int'(fwd_b0), 1);
      chk("fw.ex_pc_le", int'(pc_le0), 1);
      tick();
      drv(0, 0, 3, 2'b01, 0, 0, 0, 0); #1;
      chk("fw.mem", int'(fwd_b0), 2);
      tick();
      #1 chk("fw.wb", int'(fwd_b0), 3);
      tick();

      // r3 in EX and WB: EX wins
      drv(1, 0, 0, 2'b00, 3, 1, 0, 0); tick();
      drv(1, 0, 0, 2'b00, 9, 0, 0, 0); tick();
      drv(1, 0, 0, 2'b00, 3, 1, 0, 0); tick();
      drv(1, 3, 3, 2'b11, 10, 0, 0, 0); #1;
      chk("prio.fwd_a", int'(fwd_a0), 1);
      chk("prio.fwd_b", int'(fwd_b0), 1);
      tick();

      // load to r0 then use of r0: no stall, no forward
      drv(1, 0, 0, 2'b00, 0, 1, 1, 0); tick();
      drv(1, 0, 0, 2'b11, 11, 1, 0, 0); #1;
      chk("r0.pc_le", int'(pc_le0), 1);
      chk("r0.id_nop", int'(id_nop0), 0);
      chk("r0.fwd_a", int'(fwd_a0), 0);
      chk("r0.fwd_b", int'(fwd_b0), 0);
      tick();

      // taken branch coinciding with a load-use hazard
      drv(1, 0, 0, 2'b00, 5, 1, 1, 0); tick();
      drv(1, 5, 0, 2'b10, 12, 1, 0, 1); #1;
      chk("br.ds0.if_flush", int'(if_flush1), 1);
      chk("br.ds0.id_nop", int'(id_nop1), 1);
      chk("br.ds0.pc_le", int'(pc_le1), 1);
      chk("br.ds1.if_flush", int'(if_flush0), 0);
      chk("br.ds1.pc_le", int'(pc_le0), 0);
      tick();
      drv(0, 0, 0, 2'b00, 0, 0, 0, 0); #1;
      chk("br.ds0.stall_cnt", int'(cnt1), 1);
      chk("br.ds1.stall_cnt", int'(cnt0), 2);
      chk("br.ds1.stall_pc_le", int'(pc_le0), 1);
      tick();

      // back-to-back self-dependent loads: a stall every other cycle
      drv(1, 5, 0, 2'b10, 5, 1, 1, 0);
      repeat (40) tick();
      chk("sat.cnt4", int'(cnt1), 15);
      chk("sat.cnt16", int'(cnt0), 22);
      chk("sat.in_stall_pc_le", int'(pc_le0), 1);

      // reset in the middle of the stall cycle
      #1 reset_n = 1'b0;
      #1;
      chk("midrst.pc_le", int'(pc_le0), 0);
      chk("midrst.id_nop", int'(id_nop0), 1);
      chk("midrst.if_flush", int'(if_flush0), 1);
      chk("midrst.busy", int'(busy0), 1);
      chk("midrst.stall_cnt", int'(cnt0), 0);
      chk("midrst.fwd_a", int'(fwd_a0), 0);
      drv(0, 0, 0, 2'b00, 0, 0, 0, 0);
      tick();
      reset_n = 1'b1;
      boot_check("reboot");
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
